// File: rtl/car_motion_controller.sv
// car_motion_controller: elevator car model, call register and door sequencing
module car_motion_controller #(
  parameter int TIMER_WIDTH   = 8,
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] call_set,
  input  logic       direction,
  input  logic       shouldMove,
  output logic [7:0] floorsCalled,
  output logic [2:0] currentFloor,
  output logic       door_open,
  output logic       moving,
  output logic       arrived
);
  typedef enum logic [1:0] {IDLE, MOVE, DOOR, SETTLE} state_t;
  localparam logic [TIMER_WIDTH-1:0] T_TRAVEL = TIMER_WIDTH'(TRAVEL_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] T_DOOR   = TIMER_WIDTH'(DOOR_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] T_SETTLE = TIMER_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] ONE      = TIMER_WIDTH'(1);
  state_t                 state, state_n;
  logic [TIMER_WIDTH-1:0] timer, timer_n;
  logic [2:0]             floor_n, step_floor;
  logic [7:0]             hit, clr;
  logic                   dir_q, dir_n, arrived_n;
  assign door_open = (state == DOOR);
  assign moving    = (state == MOVE);
  // Next state, shared timer reload and the one-hot clear of the served floor's call
  always_comb begin
    hit        = floorsCalled | call_set;
    step_floor = dir_q ? currentFloor + 3'd1 : currentFloor - 3'd1;
    state_n    = state;
    timer_n    = timer;
    floor_n    = currentFloor;
    dir_n      = dir_q;
    arrived_n  = 1'b0;
    clr        = 8'd0;
    case (state)
      IDLE:
        if (hit[currentFloor]) begin
          state_n = DOOR;
          timer_n = T_DOOR;
          clr     = 8'd1 << currentFloor;
        end else if (shouldMove && (direction ? currentFloor != 3'd7 : currentFloor != 3'd0)) begin
          state_n = MOVE;
          dir_n   = direction;
          timer_n = T_TRAVEL;
        end
      MOVE:
        if (timer == '0) begin
          floor_n = step_floor;
          if (hit[step_floor]) begin
            state_n   = DOOR;
            timer_n   = T_DOOR;
            clr       = 8'd1 << step_floor;
            arrived_n = 1'b1;
          end else begin
            state_n = SETTLE;
            timer_n = T_SETTLE;
          end
        end else timer_n = timer - ONE;
      DOOR:
        if (call_set[currentFloor]) begin
          timer_n = T_DOOR;
          clr     = 8'd1 << currentFloor;
        end else if (timer == '0) begin
          state_n = SETTLE;
          timer_n = T_SETTLE;
        end else timer_n = timer - ONE;
      default: begin
        state_n = timer == '0 ? IDLE : SETTLE;
        timer_n = timer == '0 ? timer : timer - ONE;
      end
    endcase
  end
  // State, position and call registers; reset snaps the car to floor 0 from any state
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= SETTLE;
      timer        <= T_SETTLE;
      floorsCalled <= 8'd0;
      currentFloor <= 3'd0;
      dir_q        <= 1'b0;
      arrived      <= 1'b0;
    end else begin
      state        <= state_n;
      timer        <= timer_n;
      floorsCalled <= (floorsCalled | call_set) & ~clr;
      currentFloor <= floor_n;
      dir_q        <= dir_n;
      arrived      <= arrived_n;
    end
  end
endmodule

// File: tb/tb_car_motion_controller.sv
// tb_car_motion_controller: scoreboard bench with a behavioural direction calculator
module tb_car_motion_controller;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] call_set = 8'd0;
  logic       direction, shouldMove;
  logic [7:0] floorsCalled;
  logic [2:0] currentFloor;
  logic       door_open, moving, arrived;
  logic       dc_dir = 1'b0, dc_sm = 1'b0;
  logic       stub = 1'b0, stub_dir = 1'b0, stub_sm = 1'b0;
  logic [7:0] above_m, below_m;
  int errors = 0, checks = 0;
  typedef struct {int ev; int floor; int calls; int aux;} exp_t;
  exp_t q[$];
  car_motion_controller dut (
    .clock(clock), .reset(reset), .call_set(call_set), .direction(direction),
    .shouldMove(shouldMove), .floorsCalled(floorsCalled), .currentFloor(currentFloor),
    .door_open(door_open), .moving(moving), .arrived(arrived)
  );
  always #5 clock = ~clock;
  initial begin
    #5_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  // Direction calculator model: one registered cycle of latency, keeps heading while calls remain ahead
  always_comb begin
    above_m = floorsCalled & ~((8'd2 << currentFloor) - 8'd1);
    below_m = floorsCalled & ((8'd1 << currentFloor) - 8'd1);
  end
  always @(posedge clock) begin
    if (!reset) begin
      dc_dir <= 1'b0;
      dc_sm  <= 1'b0;
    end else begin
      dc_sm  <= (|above_m) || (|below_m);
      dc_dir <= (|above_m) && (dc_dir || !(|below_m));
    end
  end
  assign direction  = stub ? stub_dir : dc_dir;
  assign shouldMove = stub ? stub_sm : dc_sm;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  // Monitor: events are move start (0), door open (1, aux=arrived) and door close (2, aux=open cycles)
  task automatic got(input int ev, input int f, input int c, input int a);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got ev=%0d floor=%0d calls=%0h aux=%0d expected none", ev, f, c, a);
    end else begin
      e = q.pop_front();
      if (e.ev != ev || e.floor != f || e.calls != c || e.aux != a) begin
        errors++;
        $display("FAIL event: got ev=%0d floor=%0d calls=%0h aux=%0d expected ev=%0d floor=%0d calls=%0h aux=%0d",
                 ev, f, c, a, e.ev, e.floor, e.calls, e.aux);
      end
    end
  endtask
  logic pm = 1'b0, pd = 1'b0;
  int dcnt = 0;
  always @(negedge clock) begin
    if (moving && !pm) got(0, int'(currentFloor), int'(floorsCalled), 0);
    if (door_open && !pd) begin
      dcnt = 1;
      got(1, int'(currentFloor), int'(floorsCalled), int'(arrived));
    end else if (door_open) dcnt++;
    if (!door_open && pd) got(2, int'(currentFloor), int'(floorsCalled), dcnt);
    if (arrived) chk("arrived_on_door_rise", 32'(door_open && !pd), 32'd1);
    pm = moving;
    pd = door_open;
  end
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic push(input int ev, input int f, input int c, input int a);
    exp_t e;
    e = '{ev, f, c, a};
    q.push_back(e);
  endtask
  task automatic pulse(input logic [7:0] v);
    call_set = v;
    tick();
    call_set = 8'd0;
  endtask
  task automatic wait_drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    chk(name, 32'(q.size()), 32'd0);
    q.delete();
    repeat (5) tick();
  endtask
  task automatic hold_stub(input string name, input logic d, input logic [2:0] f);
    logic moved = 1'b0;
    stub = 1'b1;
    stub_dir = d;
    stub_sm = 1'b1;
    repeat (100) begin
      tick();
      if (moving) moved = 1'b1;
    end
    chk({name, "_moved"}, 32'(moved), 32'd0);
    chk({name, "_floor"}, 32'(currentFloor), 32'(f));
    stub = 1'b0;
    stub_sm = 1'b0;
    repeat (3) tick();
  endtask
  initial begin
    int n;
    repeat (3) tick();
    chk("rst_floor", 32'(currentFloor), 32'd0);
    chk("rst_calls", 32'(floorsCalled), 32'd0);
    chk("rst_door", 32'(door_open), 32'd0);
    chk("rst_moving", 32'(moving), 32'd0);
    chk("rst_arrived", 32'(arrived), 32'd0);
    reset = 1'b1;
    repeat (5) tick();
    for (int f = 0; f < 5; f++) push(0, f, 'h20, 0);
    push(1, 5, 0, 1);
    push(2, 5, 0, 32);
    pulse(8'h20);
    chk("t1_latched", 32'(floorsCalled), 32'h20);
    wait_drain("t1_drain");
    push(1, 5, 0, 0);
    push(2, 5, 0, 52);
    pulse(8'h20);
    chk("t3_door", 32'(door_open), 32'd1);
    repeat (19) tick();
    pulse(8'h20);
    chk("t3_absorbed", 32'(floorsCalled), 32'd0);
    wait_drain("t3_drain");
    for (int f = 5; f > 0; f--) push(0, f, 'h01, 0);
    push(1, 0, 0, 1);
    push(2, 0, 0, 32);
    pulse(8'h01);
    wait_drain("down_drain");
    push(1, 0, 0, 0);
    push(2, 0, 0, 32);
    pulse(8'h01);
    chk("t2_door", 32'(door_open), 32'd1);
    chk("t2_calls", 32'(floorsCalled), 32'd0);
    chk("t2_arrived", 32'(arrived), 32'd0);
    wait_drain("t2_drain");
    push(0, 0, 'h44, 0);
    push(0, 1, 'h44, 0);
    push(1, 2, 'h40, 1);
    push(2, 2, 'h40, 32);
    for (int f = 2; f < 6; f++) push(0, f, 'h40, 0);
    push(1, 6, 0, 1);
    push(2, 6, 0, 32);
    pulse(8'h44);
    wait_drain("t4_drain");
    chk("t4_floor", 32'(currentFloor), 32'd6);
    chk("t4_calls", 32'(floorsCalled), 32'd0);
    push(0, 6, 'h80, 0);
    push(1, 7, 0, 1);
    push(2, 7, 0, 32);
    pulse(8'h80);
    wait_drain("to7_drain");
    hold_stub("t5_top", 1'b1, 3'd7);
    for (int f = 7; f > 0; f--) push(0, f, 'h01, 0);
    push(1, 0, 0, 1);
    push(2, 0, 0, 32);
    pulse(8'h01);
    wait_drain("to0_drain");
    hold_stub("t5_bottom", 1'b0, 3'd0);
    for (int f = 0; f < 4; f++) push(0, f, 'h80, 0);
    pulse(8'h80);
    n = 0;
    while (!(moving && currentFloor == 3'd3) && n < 2000) begin
      tick();
      n++;
    end
    chk("t6_reach", 32'(moving && currentFloor == 3'd3), 32'd1);
    repeat (8) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("t6_floor", 32'(currentFloor), 32'd0);
    chk("t6_calls", 32'(floorsCalled), 32'd0);
    chk("t6_moving", 32'(moving), 32'd0);
    chk("t6_door", 32'(door_open), 32'd0);
    chk("t6_arrived", 32'(arrived), 32'd0);
    chk("t6_events", 32'(q.size()), 32'd0);
    repeat (20) tick();
    chk("final_floor", 32'(currentFloor), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
